// File: rtl/bloom_pkg.sv
// rtl/bloom_pkg.sv - shared FSM states, op codes and rotate helper for the bloom filter
package bloom_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PROBE = 2'd1,
    ST_CLEAR = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  localparam logic [1:0] OP_QUERY  = 2'b00;
  localparam logic [1:0] OP_INSERT = 2'b01;
  localparam logic [1:0] OP_CLEAR  = 2'b10;

  localparam int ROT_STEP = 7;

  function automatic logic [63:0] rotl64(input logic [63:0] k, input int n);
    logic [127:0] d;
    d = {k, k} << (n % 64);
    return d[127:64];
  endfunction

endpackage

// File: rtl/bloom_hash.sv
// rtl/bloom_hash.sv - combinational XOR-fold hashes of a 64-bit key, one per probe
module bloom_hash
  import bloom_pkg::*;
#(
  parameter int NUM_HASH   = 3,
  parameter int HASH_WIDTH = 10
) (
  input  logic [63:0]                     key,
  output logic [NUM_HASH*HASH_WIDTH-1:0]  idx
);

  localparam int SLICES = (64 + HASH_WIDTH - 1) / HASH_WIDTH;
  localparam int PAD_W  = SLICES * HASH_WIDTH;

  // Zero-extending to a whole number of slices pads the top slice with zeros.
  function automatic logic [HASH_WIDTH-1:0] fold(input logic [63:0] k);
    logic [PAD_W-1:0]      pad;
    logic [HASH_WIDTH-1:0] f;
    pad = PAD_W'(k);
    f   = '0;
    for (int s = 0; s < SLICES; s++) begin
      f = f ^ pad[s*HASH_WIDTH +: HASH_WIDTH];
    end
    return f;
  endfunction

  always_comb begin
    idx = '0;
    for (int h = 0; h < NUM_HASH; h++) begin
      idx[h*HASH_WIDTH +: HASH_WIDTH] = fold(rotl64(key, ROT_STEP*h + 1));
    end
  end

endmodule

// File: rtl/bloom_filter_multi.sv
// rtl/bloom_filter_multi.sv - multi-hash bloom filter with query/insert/clear and held response
module bloom_filter_multi
  import bloom_pkg::*;
#(
  parameter int BIT_ARRAY_SIZE = 1024,
  parameter int NUM_HASH       = 3,
  parameter int CLEAR_W        = 32,
  parameter int TAG_W          = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [31:0]      src_ip,
  input  logic [31:0]      dest_ip,
  input  logic [TAG_W-1:0] tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             safe,
  output logic [63:0]      header,
  output logic [TAG_W-1:0] out_tag,
  output logic [1:0]       out_op,
  output logic             busy
);

  localparam int HASH_WIDTH = $clog2(BIT_ARRAY_SIZE);
  localparam int CLR_N      = BIT_ARRAY_SIZE / CLEAR_W;
  localparam int CLR_CW     = (CLR_N > 1) ? $clog2(CLR_N) : 1;
  localparam int PRB_CW     = (NUM_HASH > 1) ? $clog2(NUM_HASH) : 1;

  state_t state, state_nxt;

  logic [BIT_ARRAY_SIZE-1:0]              bits;
  logic [NUM_HASH*HASH_WIDTH-1:0]         hash_idx;
  logic [NUM_HASH-1:0][HASH_WIDTH-1:0]    idx_q;
  logic [PRB_CW-1:0]                      pcnt;
  logic [CLR_CW-1:0]                      ccnt;
  logic                                   match;
  logic [HASH_WIDTH-1:0]                  cur_idx;
  logic                                   probe_bit;
  logic                                   probe_last;
  logic                                   probe_stop;
  logic                                   clear_last;

  bloom_hash #(
    .NUM_HASH   (NUM_HASH),
    .HASH_WIDTH (HASH_WIDTH)
  ) u_hash (
    .key (header_in()),
    .idx (hash_idx)
  );

  function automatic logic [63:0] header_in();
    return {src_ip, dest_ip};
  endfunction

  // Only inserts run every probe; queries and the reserved op stop on the first clear bit.
  assign cur_idx    = idx_q[pcnt];
  assign probe_bit  = bits[cur_idx];
  assign probe_last = (pcnt == PRB_CW'(NUM_HASH - 1));
  assign probe_stop = probe_last || ((out_op != OP_INSERT) && !probe_bit);
  assign clear_last = (ccnt == CLR_CW'(CLR_N - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (in_valid) state_nxt = (in_op == OP_CLEAR) ? ST_CLEAR : ST_PROBE;
      ST_PROBE: if (probe_stop) state_nxt = ST_RESP;
      ST_CLEAR: if (clear_last) state_nxt = ST_RESP;
      ST_RESP:  if (out_ready) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == ST_IDLE);
    out_valid = (state == ST_RESP);
    busy      = (state != ST_IDLE);
  end

  // Insert writes land before the next probe reads, so repeated indices see their own update.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bits    <= '0;
      idx_q   <= '0;
      pcnt    <= '0;
      ccnt    <= '0;
      match   <= 1'b0;
      safe    <= 1'b0;
      header  <= '0;
      out_tag <= '0;
      out_op  <= OP_QUERY;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            header  <= header_in();
            out_tag <= tag;
            out_op  <= in_op;
            idx_q   <= hash_idx;
            pcnt    <= '0;
            ccnt    <= '0;
            match   <= 1'b1;
          end
        end
        ST_PROBE: begin
          if (out_op == OP_INSERT) bits[cur_idx] <= 1'b1;
          match <= match & probe_bit;
          pcnt  <= pcnt + 1'b1;
          if (probe_stop) safe <= match & probe_bit;
        end
        ST_CLEAR: begin
          for (int w = 0; w < CLR_N; w++) begin
            if (ccnt == CLR_CW'(w)) bits[w*CLEAR_W +: CLEAR_W] <= '0;
          end
          ccnt <= ccnt + 1'b1;
          if (clear_last) safe <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bloom_filter_multi.sv
// tb/tb_bloom_filter_multi.sv - randomized self-checking bench against a behavioural bloom model
module tb_bloom_filter_multi;

  localparam int N  = 1024;
  localparam int NH = 3;
  localparam int CW = 32;
  localparam int TW = 16;
  localparam int HW = 10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [1:0]    in_op = 2'b00;
  logic [31:0]   src_ip = '0;
  logic [31:0]   dest_ip = '0;
  logic [TW-1:0] tag = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          safe;
  logic [63:0]   header;
  logic [TW-1:0] out_tag;
  logic [1:0]    out_op;
  logic          busy;

  always #5 clk = ~clk;

  bloom_filter_multi #(
    .BIT_ARRAY_SIZE (N),
    .NUM_HASH       (NH),
    .CLEAR_W        (CW),
    .TAG_W          (TW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .src_ip    (src_ip),
    .dest_ip   (dest_ip),
    .tag       (tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .safe      (safe),
    .header    (header),
    .out_tag   (out_tag),
    .out_op    (out_op),
    .busy      (busy)
  );

  int          total = 0;
  int          bad = 0;
  bit [N-1:0]  mbits = '0;
  int          obs_lat;
  logic        obs_safe;
  logic [31:0] pool_s [8];
  logic [31:0] pool_d [8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Bit b of a left rotation by r comes from key bit (b - r) mod 64; bit b folds onto position b mod HW.
  function automatic int mhash(input logic [63:0] key, input int i);
    int r;
    int h;
    r = (7*i + 1) % 64;
    h = 0;
    for (int b = 0; b < 64; b++) begin
      if (key[(b - r + 64) % 64]) h = h ^ (1 << (b % HW));
    end
    return h;
  endfunction

  task automatic model(input logic [1:0] op, input logic [63:0] key, output logic es, output int elat);
    logic m;
    int   h;
    if (op == 2'b10) begin
      mbits = '0;
      es    = 1'b0;
      elat  = N/CW + 1;
    end else if (op == 2'b01) begin
      m = 1'b1;
      for (int i = 0; i < NH; i++) begin
        h = mhash(key, i);
        m = m & mbits[h];
        mbits[h] = 1'b1;
      end
      es   = m;
      elat = NH + 1;
    end else begin
      es   = 1'b1;
      elat = NH + 1;
      for (int i = 0; i < NH; i++) begin
        h = mhash(key, i);
        if (!mbits[h]) begin
          es   = 1'b0;
          elat = i + 2;
          break;
        end
      end
    end
  endtask

  task automatic wait_idle();
    int w;
    w = 0;
    while (!in_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    chk("in_ready_before_req", in_ready, 1);
  endtask

  task automatic noise();
    in_valid = 1'($urandom_range(0, 1));
    in_op    = 2'($urandom);
    src_ip   = $urandom;
    dest_ip  = $urandom;
    tag      = TW'($urandom);
  endtask

  task automatic run_req(input logic [1:0] op, input logic [31:0] s, input logic [31:0] d,
                         input logic [TW-1:0] t, input int hold);
    logic        es;
    int          elat;
    logic [63:0] key;
    key = {s, d};
    @(negedge clk);
    wait_idle();
    in_valid = 1'b1; in_op = op; src_ip = s; dest_ip = d; tag = t; out_ready = 1'b0;
    model(op, key, es, elat);
    obs_lat  = -1;
    obs_safe = 1'b0;
    for (int k = 1; k <= elat; k++) begin
      @(negedge clk);
      noise();
      chk("out_valid_timing", out_valid, (k == elat));
      chk("busy_active", busy, 1);
      if (out_valid && obs_lat < 0) begin
        obs_lat  = k;
        obs_safe = safe;
      end
    end
    out_ready = (hold == 0);
    for (int h = 0; h <= hold; h++) begin
      if (h > 0) begin
        @(negedge clk);
        noise();
        if (h == hold) out_ready = 1'b1;
      end
      chk("resp_valid", out_valid, 1);
      chk("resp_safe", safe, es);
      chk("resp_header", header, key);
      chk("resp_tag", out_tag, t);
      chk("resp_op", out_op, op);
      chk("resp_in_ready_low", in_ready, 0);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("after_resp_valid", out_valid, 0);
    chk("after_resp_in_ready", in_ready, 1);
    chk("popcount", $countones(dut.bits), $countones(mbits));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    mbits = '0;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_array_zero", $countones(dut.bits), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", in_ready, 1);
    chk("post_rst_out_valid", out_valid, 0);
  endtask

  task automatic abort_req(input logic [1:0] op, input logic [63:0] key, input int cycles);
    @(negedge clk);
    wait_idle();
    in_valid = 1'b1; in_op = op; src_ip = key[63:32]; dest_ip = key[31:0]; out_ready = 1'b1;
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      in_valid = 1'b0;
      chk("abort_no_valid", out_valid, 0);
    end
    do_reset();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("abort_quiet", out_valid, 0);
    end
  endtask

  localparam logic [63:0] KEY_A = 64'h0A00_0001_0A00_0002;

  initial begin
    int          p1;
    int          r;
    int          sel;
    logic [1:0]  op;
    for (int i = 0; i < 8; i++) begin
      pool_s[i] = $urandom;
      pool_d[i] = $urandom;
    end

    repeat (2) @(negedge clk);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_safe", safe, 0);
    chk("reset_header", header, 0);
    chk("reset_tag", out_tag, 0);
    chk("reset_op", out_op, 0);
    chk("reset_busy", busy, 0);
    chk("reset_array", $countones(dut.bits), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_in_ready", in_ready, 1);

    chk("model_hash0", mhash(KEY_A, 0), 77);
    chk("model_hash1", mhash(KEY_A, 1), 547);

    run_req(2'b00, KEY_A[63:32], KEY_A[31:0], 16'h1234, 0);
    chk("q0_latency", obs_lat, 2);
    chk("q0_safe", obs_safe, 0);

    run_req(2'b01, KEY_A[63:32], KEY_A[31:0], 16'h0001, 0);
    chk("ins_latency", obs_lat, 4);
    chk("ins_safe", obs_safe, 0);
    p1 = $countones(dut.bits);

    run_req(2'b00, KEY_A[63:32], KEY_A[31:0], 16'h0002, 1);
    chk("q1_latency", obs_lat, 4);
    chk("q1_safe", obs_safe, 1);

    run_req(2'b01, KEY_A[63:32], KEY_A[31:0], 16'h0003, 0);
    chk("dup_ins_safe", obs_safe, 1);
    chk("dup_ins_popcount", $countones(dut.bits), p1);

    run_req(2'b11, KEY_A[63:32], KEY_A[31:0], 16'h0004, 2);
    chk("rsvd_safe", obs_safe, 1);
    chk("rsvd_popcount", $countones(dut.bits), p1);

    run_req(2'b10, 32'h0, 32'h0, 16'h0005, 5);
    chk("clear_latency", obs_lat, 33);
    chk("clear_safe", obs_safe, 0);

    run_req(2'b00, KEY_A[63:32], KEY_A[31:0], 16'h0006, 0);
    chk("q_after_clear_safe", obs_safe, 0);
    chk("q_after_clear_latency", obs_lat, 2);

    run_req(2'b01, KEY_A[63:32], KEY_A[31:0], 16'h0007, 0);
    abort_req(2'b01, {pool_s[0], pool_d[0]}, 2);
    run_req(2'b01, pool_s[1], pool_d[1], 16'h0008, 0);
    abort_req(2'b10, 64'h0, 10);

    for (int n = 0; n < 80; n++) begin
      r   = $urandom_range(0, 19);
      sel = $urandom_range(0, 7);
      if (r < 9)       op = 2'b00;
      else if (r < 17) op = 2'b01;
      else if (r < 19) op = 2'b11;
      else             op = 2'b10;
      run_req(op, pool_s[sel], pool_d[sel], TW'($urandom), $urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
